antirrebote_incremento: RTL

Debounce and single-pulse generator that sits directly upstream of the decade counter and drives its `incremento` input. Takes a raw, asynchronous, bouncing pushbutton level and produces exactly one clock-wide `incremento` pulse per confirmed press. An optional auto-repeat mode emits further pulses while the button is held.

---
 rtl/antirrebote_incremento.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/antirrebote_incremento.sv
// Pushbutton debouncer that emits one clock-wide incremento pulse per confirmed press.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module antirrebote_incremento #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic incremento,
  output logic boton_limpio
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRMA_PRESION,
    PRESIONADO,
    CONFIRMA_LIBERACION
  } estado_t;

  estado_t       estado, estado_sig;
  logic [CW-1:0] cuenta, cuenta_sig;
  logic          s1, boton_s;
  logic          pulso_sig, limpio_sig, repite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      boton_s <= 1'b0;
    end else begin
      s1      <= boton;
      boton_s <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= IDLE;
      cuenta       <= '0;
      incremento   <= 1'b0;
      boton_limpio <= 1'b0;
    end else begin
      estado       <= estado_sig;
      cuenta       <= cuenta_sig;
      incremento   <= pulso_sig;
      boton_limpio <= limpio_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    cuenta_sig = cuenta;
    case (estado)
      IDLE: begin
        if (boton_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            estado_sig = PRESIONADO;
          end else begin
            estado_sig = CONFIRMA_PRESION;
            cuenta_sig = CW'(1);
          end
        end
      end
      CONFIRMA_PRESION: begin
        if (!boton_s) begin
          estado_sig = IDLE;
          cuenta_sig = '0;
        end else if (cuenta == ULTIMO) begin
          estado_sig = PRESIONADO;
          cuenta_sig = '0;
        end else begin
          cuenta_sig = cuenta + CW'(1);
        end
      end
      PRESIONADO: begin
        if (!boton_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            estado_sig = IDLE;
          end else begin
            estado_sig = CONFIRMA_LIBERACION;
            cuenta_sig = CW'(1);
          end
        end
      end
      CONFIRMA_LIBERACION: begin
        if (boton_s) begin
          estado_sig = PRESIONADO;
          cuenta_sig = '0;
        end else if (cuenta == ULTIMO) begin
          estado_sig = IDLE;
          cuenta_sig = '0;
        end else begin
          cuenta_sig = cuenta + CW'(1);
        end
      end
      default: begin
        estado_sig = IDLE;
        cuenta_sig = '0;
      end
    endcase
  end

  // A press pulse is any entry into PRESIONADO that is not a return from release bounce.
  always_comb begin
    pulso_sig  = repite;
    limpio_sig = (estado_sig == PRESIONADO) || (estado_sig == CONFIRMA_LIBERACION);
    if ((estado == IDLE || estado == CONFIRMA_PRESION) && estado_sig == PRESIONADO)
      pulso_sig = 1'b1;
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

  logic [RW-1:0] rep;
  logic [RW-1:0] objetivo;
  logic          primera;

  // rep counts cycles spent continuously in PRESIONADO since the last pulse.
  assign objetivo = primera ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
  assign repite   = (estado == PRESIONADO) && (estado_sig == PRESIONADO) &&
                    (rep + RW'(1) == objetivo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep     <= '0;
      primera <= 1'b1;
    end else if (estado != PRESIONADO || estado_sig != PRESIONADO) begin
      rep     <= '0;
      primera <= 1'b1;
    end else if (repite) begin
      rep     <= '0;
      primera <= 1'b0;
    end else begin
      rep     <= rep + RW'(1);
    end
  end
`else
  assign repite = 1'b0;
`endif

endmodule
